// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, added LSB first over WIDTH
// cycles through a single full adder, and the registered result is published on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    // Full adder as two half-adder stages plus OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
    always_comb begin
        ha1_s = a_sh_q[0] ^ b_sh_q[0];
        ha1_c = a_sh_q[0] & b_sh_q[0];
        ha2_s = ha1_s ^ carry_q;
        ha2_c = ha1_s & carry_q;
        fa_c  = ha1_c | ha2_c;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {ha2_s, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                if (cnt_q == LAST) begin
                    // Counter holds at its last value so it never wraps.
                    sum_d   = {ha2_s, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
endmodule
